hello_main: RTL and testbench
=============================

# hello_main

Top-level "hello world" demo for the fake-FPGA board model (module `main`). Drives "HELLO" on the six 7-segment displays, with optional scrolling. Mirrors switches onto LEDs. Draws a 16x16 coloured square on the 160x120 VGA pixel interface on a key press. It sits directly under the board testbench, which supplies the 50 MHz clock and samples all outputs.

## Interface
- Reset: one clock; reset is synchronous and active-high, driven by KEY[0] on CLOCK_50.
- SCROLL_DIV, default 25_000_000: clock cycles per one-position scroll step (0.5 s at 50 MHz).
- CLOCK_50  in  1  50 MHz clock; all state updates on its rising edge.
- KEY  in  4  push buttons, active-high.
  - KEY[0]: synchronous reset.
  - KEY[1]: draw.
  - KEY[2]: clear screen.
  - KEY[3]: scroll pause.
- SW  in  10  switches.
  - SW[0]: scroll enable.
  - SW[3:1]: square row index.
  - SW[6:4]: square column index.
  - SW[9:7]: colour.
- HEX  out  48  six displays. HEX[8i+7:8i] is HEXi, with bit 7 = dp and bits 6:0 = segments g..a, active-high (1 = lit). HEX5 = HEX[47:40] is leftmost.
- LED  out  10  LED[8:0] mirrors SW[8:0]; LED[9] = draw busy.
- x  out  8  pixel column, 0..159.
- y  out  7  pixel row, 0..119.
- colour  out  3  pixel colour, 0..7.
- plot  out  1  pixel written in each cycle where plot=1.
- vga_resetn  out  1  active-low; the screen clears to black in each cycle where it is 0.

## Operation
- All outputs are registered.
- Reset values:
  - HEX = 76_79_38_38_3F_00 hex (HEX5..HEX0).
  - LED = 0.
  - x = 0, y = 0, colour = 0, plot = 0.
  - vga_resetn = 0 while reset is asserted.
  - FSM in IDLE, scroll pointer = 0, divider = 0.
- Key edge detection: prev-registers for KEY[2:1] load KEY during reset, so a key held through reset release is not an edge. An edge is KEY[n]=1 with prev=0.
- Message ring of six characters, index 0..5: H=76, E=79, L=38, L=38, O=3F, blank=00 (hex).
- HEX(5-k) shows ring[(ptr+k) mod 6] for k = 0..5.
- Scrolling: when SW[0]=1 and KEY[3]=0, the divider counts. When the divider reaches SCROLL_DIV-1 it wraps to 0 and ptr increments mod 6 (5 -> 0). Otherwise the divider holds; it is not cleared while paused.
- LED[8:0] <= SW[8:0] every cycle. LED[9] = 1 while in DRAW.
- FSM states: IDLE and DRAW.
- IDLE -> DRAW on a KEY[1] edge, unless a KEY[2] edge occurs in the same cycle; clear wins and the draw is dropped.
  - On entry, latch x0 = SW[6:4]*16, y0 = SW[3:1]*16 and col = SW[9:7].
  - Counters cx = cy = 0.
- DRAW, one pixel per cycle, row-major (cx fastest, 0..15, then cy++):
  - x = x0+cx, y = y0+cy (low 7 bits), colour = col.
  - plot = 1 only if y0+cy < 120. Rows 120..127 are clipped with plot = 0 but still take their cycles.
  - x never exceeds 127, so no x clip is needed.
- After pixel (15,15) -> IDLE, plot = 0.
- KEY[1] edges while in DRAW are ignored, and switch changes do not affect a square in progress.
- KEY[2] edge in any state: vga_resetn = 0 for exactly one cycle. If in DRAW, the square is aborted -> IDLE and plot = 0 in that same cycle.
- x, y and colour hold their last values in IDLE.

## Timing
- Edge detected at clock edge E: pixel (0,0) appears on the outputs after edge E, and pixel k after edge E+k.
- plot is driven for exactly 256 cycles (E..E+255), minus clipped rows. plot = 0 after edge E+256.
- LED[9] rises after E and falls after E+256.
- Clear pulse: vga_resetn = 0 from edge E to edge E+1.
- Scroll step occurs every SCROLL_DIV enabled cycles. Latency from the terminal count to the new HEX is one cycle.
- Reset asserted mid-draw or mid-clear: all outputs take their reset values on the next edge.

## Test plan
- Reset, then release with SW=0 -> HEX = 7679_3838_3F00 hex; LED = 0; plot = 0; vga_resetn = 1 after release.
- SCROLL_DIV=4, SW[0]=1, run 4 cycles -> HEX5..0 = 79,38,38,3F,00,76. After 24 cycles the display is back to the reset pattern. KEY[3]=1 freezes it.
- SW = 10_0011_0010 binary, then a KEY[1] pulse -> 256 cycles of plot = 1, colour = 4, x = 48..63, y = 16..31 row-major; LED[9] is high for 256 cycles.
- SW[3:1]=7, KEY[1] pulse -> rows 112..119 have plot = 1 (128 pixels); rows 120..127 have plot = 0; total duration is 256 cycles.
- KEY[2] pulse at pixel 100 of a draw -> vga_resetn = 0 for one cycle; plot = 0 from that cycle on; LED[9] = 0. A KEY[1] edge in the same cycle as the KEY[2] edge in IDLE -> no draw.
- Hold KEY[1]=1 across reset release -> no draw starts. Release then press again -> the draw starts.

Source files
------------

// File: rtl/hello_main.sv
// hello_main: HELLO scroller on six 7-segment displays, switch-to-LED mirror and 16x16 square plotter on a 160x120 pixel port
module hello_main #(
    parameter int SCROLL_DIV = 25_000_000
) (
    input  logic        CLOCK_50,
    input  logic [3:0]  KEY,
    input  logic [9:0]  SW,
    output logic [47:0] HEX,
    output logic [9:0]  LED,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        vga_resetn
);
    localparam int DW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCROLL_DIV - 1);
    // message written twice so any six-character window is one contiguous slice
    localparam logic [95:0] MSG2 = {2{48'h7679_3838_3F00}};

    typedef enum logic {IDLE, DRAW} state_t;

    state_t          state, state_n;
    logic            rst;
    logic [2:1]      key_q;
    logic            draw_edge, clr_edge, start, active, plot_n;
    logic [DW-1:0]   div, div_n;
    logic [2:0]      ptr, ptr_n;
    logic [7:0]      x0, x0_n, x_n, pix;
    logic [6:0]      y0, y0_n, y_n, row;
    logic [2:0]      col, col_n, colour_n;
    logic [8:0]      cnt, cnt_n;
    logic [47:0]     hex_n;

    assign rst       = KEY[0];
    assign draw_edge = KEY[1] & ~key_q[1];
    assign clr_edge  = KEY[2] & ~key_q[2];

    // FSM state register
    always_ff @(posedge CLOCK_50) state <= rst ? IDLE : state_n;

    // next state: clear beats everything, then a new square, then end of square
    always_comb begin
        state_n = clr_edge                            ? IDLE
                : (state == IDLE && draw_edge)        ? DRAW
                : (state == DRAW && cnt == 9'd256)    ? IDLE
                : state;
    end

    // pixel outputs: pixel 0 is emitted on the very edge that starts the square
    always_comb begin
        start    = (state == IDLE) && draw_edge && !clr_edge;
        active   = (state_n == DRAW);
        x0_n     = start ? {1'b0, SW[6:4], 4'b0000} : x0;
        y0_n     = start ? {SW[3:1], 4'b0000} : y0;
        col_n    = start ? SW[9:7] : col;
        pix      = start ? 8'd0 : cnt[7:0];
        cnt_n    = active ? {1'b0, pix} + 9'd1 : 9'd0;
        row      = y0_n + {3'b000, pix[7:4]};
        x_n      = active ? x0_n + {4'b0000, pix[3:0]} : x;
        y_n      = active ? row : y;
        colour_n = active ? col_n : colour;
        plot_n   = active && (row < 7'd120);
    end

    // scroll divider and ring pointer; the divider holds its count while paused
    always_comb begin
        div_n = div;
        ptr_n = ptr;
        if (SW[0] && !KEY[3]) begin
            div_n = (div == DIV_LAST) ? '0 : div + DW'(1);
            ptr_n = (div != DIV_LAST) ? ptr : (ptr == 3'd5) ? 3'd0 : ptr + 3'd1;
        end
        hex_n = MSG2[7'd95 - {1'b0, ptr_n, 3'b000} -: 48];
    end

    // registered datapath and outputs; key history loads even in reset
    always_ff @(posedge CLOCK_50) begin
        key_q <= KEY[2:1];
        if (rst) begin
            div        <= '0;
            ptr        <= 3'd0;
            x0         <= 8'd0;
            y0         <= 7'd0;
            col        <= 3'd0;
            cnt        <= 9'd0;
            HEX        <= MSG2[95:48];
            LED        <= 10'd0;
            x          <= 8'd0;
            y          <= 7'd0;
            colour     <= 3'd0;
            plot       <= 1'b0;
            vga_resetn <= 1'b0;
        end else begin
            div        <= div_n;
            ptr        <= ptr_n;
            x0         <= x0_n;
            y0         <= y0_n;
            col        <= col_n;
            cnt        <= cnt_n;
            HEX        <= hex_n;
            LED        <= {active, SW[8:0]};
            x          <= x_n;
            y          <= y_n;
            colour     <= colour_n;
            plot       <= plot_n;
            vga_resetn <= ~clr_edge;
        end
    end
endmodule

// File: tb/tb_hello_main.sv
// tb_hello_main: randomized scoreboard bench for hello_main against a cycle-counting reference model
module tb_hello_main;
    localparam int SD = 4;

    logic        CLOCK_50 = 1'b0;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic [47:0] HEX;
    logic [9:0]  LED;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        vga_resetn;

    hello_main #(.SCROLL_DIV(SD)) dut (
        .CLOCK_50(CLOCK_50), .KEY(KEY), .SW(SW), .HEX(HEX), .LED(LED),
        .x(x), .y(y), .colour(colour), .plot(plot), .vga_resetn(vga_resetn)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int         c;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] col;
    } px_t;

    px_t         q[$];
    logic [7:0]  ring [6] = '{8'h76, 8'h79, 8'h38, 8'h38, 8'h3F, 8'h00};
    int          n_cmp = 0, n_bad = 0;
    int          cyc = 0, start = 0, en = 0;
    bit          mv = 0, drawing = 0, pk1 = 0, pk2 = 0;
    logic        exp_rstn;
    logic [9:0]  exp_led;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [47:0] hex_of(int steps);
        logic [47:0] h;
        for (int k = 0; k < 6; k++) h[8*(5-k) +: 8] = ring[(steps + k) % 6];
        return h;
    endfunction

    // reference model: counts enabled cycles and lists every pixel of a square when it starts
    always @(posedge CLOCK_50) begin
        bit e1, e2;
        int d, x0, y0, r;
        logic [2:0] c;
        cyc++;
        mv = 1;
        if (KEY[0]) begin
            drawing = 0;
            q.delete();
            en = 0;
            exp_rstn = 1'b0;
            exp_led = 10'd0;
        end else begin
            e1 = KEY[1] && !pk1;
            e2 = KEY[2] && !pk2;
            d = cyc - start;
            if (SW[0] && !KEY[3]) en++;
            if (e2) begin
                drawing = 0;
                q.delete();
            end else if (drawing && d == 256) begin
                drawing = 0;
                check("drain", 64'(q.size()), 64'd0);
            end else if (!drawing && e1) begin
                start = cyc;
                drawing = 1;
                x0 = int'(SW[6:4]) * 16;
                y0 = int'(SW[3:1]) * 16;
                c = SW[9:7];
                for (int k = 0; k < 256; k++) begin
                    r = y0 + k / 16;
                    if (r < 120) q.push_back('{cyc + k, 8'(x0 + k % 16), 7'(r), c});
                end
            end
            exp_rstn = !e2;
            exp_led = {drawing, SW[8:0]};
        end
        pk1 = KEY[1];
        pk2 = KEY[2];
    end

    // monitor: compares every output each cycle and pops the scoreboard on plotted pixels
    always @(negedge CLOCK_50) begin
        if (mv) begin
            bit exp_plot;
            px_t e;
            check("hex", 64'(HEX), 64'(hex_of(en / SD)));
            check("led", 64'(LED), 64'(exp_led));
            check("vga_resetn", 64'(vga_resetn), 64'(exp_rstn));
            exp_plot = q.size() > 0 && q[0].c == cyc;
            check("plot", 64'(plot), 64'(exp_plot));
            if (plot && q.size() > 0) begin
                e = q.pop_front();
                check("pixel", {14'd0, 32'(cyc), x, y, colour}, {14'd0, 32'(e.c), e.x, e.y, e.col});
            end else if (exp_plot) begin
                void'(q.pop_front());
            end
        end
    end

    task automatic cycles(int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic press(int b);
        KEY[b] = 1'b1;
        cycles(1);
        KEY[b] = 1'b0;
    endtask

    initial begin
        KEY = 4'b0001;
        SW = 10'd0;
        cycles(3);
        check("rst_x", 64'(x), 64'd0);
        check("rst_y", 64'(y), 64'd0);
        check("rst_colour", 64'(colour), 64'd0);
        check("rst_hex", 64'(HEX), 64'h7679_3838_3F00);
        KEY = 4'b0000;
        cycles(2);
        check("rel_rstn", 64'(vga_resetn), 64'd1);

        SW = 10'd1;
        cycles(4);
        check("scroll1", 64'(HEX), 64'h7938_383F_0076);
        cycles(20);
        check("scroll_wrap", 64'(HEX), 64'h7679_3838_3F00);
        KEY[3] = 1'b1;
        cycles(10);
        KEY[3] = 1'b0;
        cycles(5);

        SW = 10'b10_0011_0010;
        press(1);
        check("busy_rise", 64'(LED[9]), 64'd1);
        cycles(258);
        check("hold_x", 64'(x), 64'd63);
        check("hold_y", 64'(y), 64'd31);
        check("hold_colour", 64'(colour), 64'd4);

        SW = {3'd2, 3'd5, 3'd7, 1'b0};
        press(1);
        cycles(258);
        check("clip_y", 64'(y), 64'd127);
        check("clip_x", 64'(x), 64'd95);

        SW = 10'b10_0011_0010;
        press(1);
        SW = 10'($urandom);
        cycles(99);
        KEY[2] = 1'b1;
        cycles(1);
        KEY[2] = 1'b0;
        check("abort_x", 64'(x), 64'd51);
        check("abort_y", 64'(y), 64'd22);
        check("abort_busy", 64'(LED[9]), 64'd0);
        check("abort_rstn", 64'(vga_resetn), 64'd0);
        cycles(5);

        KEY = 4'b0110;
        cycles(1);
        KEY = 4'b0000;
        cycles(3);
        check("clear_wins", 64'(LED[9]), 64'd0);

        KEY = 4'b0011;
        cycles(2);
        KEY = 4'b0010;
        cycles(5);
        check("held_no_draw", 64'(LED[9]), 64'd0);
        KEY = 4'b0000;
        cycles(2);
        press(1);
        check("redraw", 64'(LED[9]), 64'd1);
        cycles(50);
        KEY[0] = 1'b1;
        cycles(1);
        check("mid_rst_plot", 64'(plot), 64'd0);
        check("mid_rst_x", 64'(x), 64'd0);
        check("mid_rst_y", 64'(y), 64'd0);
        check("mid_rst_colour", 64'(colour), 64'd0);
        KEY[0] = 1'b0;
        cycles(3);

        for (int i = 0; i < 4000; i++) begin
            KEY[1] = $urandom_range(0, 39) == 0;
            KEY[2] = $urandom_range(0, 399) == 0;
            if ($urandom_range(0, 99) == 0) KEY[3] = ~KEY[3];
            if ($urandom_range(0, 63) == 0) SW = 10'($urandom);
            cycles(1);
        end
        KEY = 4'b0000;
        cycles(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
